// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-channel clock-pattern generator.
package clkgen_pkg;

    // Widest half-period/phase field a channel may be built with.
    localparam int CW_MAX = 16;

    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_e;

    typedef logic [CW_MAX-1:0] cnt_t;

    // A half-period of zero is meaningless; run it as one cycle.
    function automatic cnt_t eff_half(input cnt_t h);
        return (h == '0) ? cnt_t'(1) : h;
    endfunction

endpackage

// File: rtl/clkgen_if.sv
// Control and pattern bundle between a stimulus master and clkgen_multi.
interface clkgen_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    load;
    logic [NCH*CW-1:0] half_per;
    logic [NCH*CW-1:0] phase;
    logic [NCH-1:0]    clk_o;
    logic [NCH-1:0]    clk_inv_o;
    logic [NCH-1:0]    pos_o;
    logic [NCH-1:0]    neg_o;
    logic [NCH-1:0]    busy_o;

    modport master (
        output en, load, half_per, phase,
        input  clk_o, clk_inv_o, pos_o, neg_o, busy_o
    );

    modport slave (
        input  en, load, half_per, phase,
        output clk_o, clk_inv_o, pos_o, neg_o, busy_o
    );
endinterface

// File: rtl/clkgen_chan.sv
// One clock-pattern channel: start-phase delay, square wave of programmable
// half-period, shadowed reconfiguration and an inverted, delayed copy.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int CW      = 8,
    parameter int INV_DLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] half_per,
    input  logic [CW-1:0] phase,
    output logic          clk_o,
    output logic          clk_inv_o,
    output logic          pos_o,
    output logic          neg_o,
    output logic          busy_o
);
    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] act_h, act_p, act_h_n, act_p_n;
    logic [CW-1:0] sh_h, sh_p, sh_h_n, sh_p_n;
    logic          busy_n;

    function automatic logic [CW-1:0] heff(input logic [CW-1:0] h);
        return CW'(eff_half(cnt_t'(h)));
    endfunction

    // Next state, counter and config; shadow is committed at the end of a high half.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        act_h_n = act_h;
        act_p_n = act_p;
        sh_h_n  = sh_h;
        sh_p_n  = sh_p;
        busy_n  = busy_o;
        if (load) begin
            sh_h_n = half_per;
            sh_p_n = phase;
            busy_n = 1'b1;
        end
        case (state)
            IDLE: begin
                if (busy_o) begin
                    act_h_n = sh_h;
                    act_p_n = sh_p;
                    busy_n  = load;
                end
                if (en) begin
                    state_n = PHASE;
                    cnt_n   = act_p_n;
                end
            end
            PHASE, LOW: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = HIGH;
                    cnt_n   = heff(act_h) - 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HIGH: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // A load on this very edge wins over the older shadow.
                    if (busy_o || load) begin
                        act_h_n = load ? half_per : sh_h;
                        act_p_n = load ? phase : sh_p;
                        busy_n  = 1'b0;
                    end
                    state_n = en ? LOW : IDLE;
                    cnt_n   = heff(act_h_n) - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, config and registered pattern outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            act_h  <= CW'(1);
            act_p  <= '0;
            sh_h   <= '0;
            sh_p   <= '0;
            busy_o <= 1'b0;
            clk_o  <= 1'b0;
            pos_o  <= 1'b0;
            neg_o  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            act_h  <= act_h_n;
            act_p  <= act_p_n;
            sh_h   <= sh_h_n;
            sh_p   <= sh_p_n;
            busy_o <= busy_n;
            clk_o  <= (state_n == HIGH);
            pos_o  <= (state_n == HIGH) && (state != HIGH);
            neg_o  <= (state == HIGH) && (state_n != HIGH);
        end
    end

    generate
        if (INV_DLY == 0) begin : g_inv_comb
            assign clk_inv_o = ~clk_o;
        end else begin : g_inv_dly
            logic [INV_DLY-1:0] dly;
            // Shift ~clk_o through INV_DLY flops; reset leaves the line at 1.
            always_ff @(posedge clk) begin
                if (rst) dly <= '1;
                else     dly <= INV_DLY'({dly, ~clk_o});
            end
            assign clk_inv_o = dly[INV_DLY-1];
        end
    endgenerate

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock-pattern generator; channels are independent.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CW      = 8,
    parameter int INV_DLY = 1
) (
    input logic   clk,
    input logic   rst,
    clkgen_if.slave bus
);
    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            clkgen_chan #(.CW(CW), .INV_DLY(INV_DLY)) u_chan (
                .clk       (clk),
                .rst       (rst),
                .en        (bus.en[i]),
                .load      (bus.load[i]),
                .half_per  (bus.half_per[i*CW +: CW]),
                .phase     (bus.phase[i*CW +: CW]),
                .clk_o     (bus.clk_o[i]),
                .clk_inv_o (bus.clk_inv_o[i]),
                .pos_o     (bus.pos_o[i]),
                .neg_o     (bus.neg_o[i]),
                .busy_o    (bus.busy_o[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi: directed scenarios then random traffic, every cycle
// compared against a waveform-queue reference model.
module tb_clkgen_multi;
    localparam int NCH     = 4;
    localparam int CW      = 8;
    localparam int INV_DLY = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clkgen_if #(.NCH(NCH), .CW(CW)) bus ();

    clkgen_multi #(.NCH(NCH), .CW(CW), .INV_DLY(INV_DLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: each running channel holds a queue of upcoming output
    // levels, refilled one half-period at a time.
    bit m_rn   [NCH];
    bit m_prev [NCH];
    bit m_pend [NCH];
    int m_h    [NCH];
    int m_p    [NCH];
    int m_sh_h [NCH];
    int m_sh_p [NCH];
    bit m_wave [NCH][$];
    bit m_hist [NCH][$];
    bit e_clk [NCH], e_inv [NCH], e_pos [NCH], e_neg [NCH], e_busy [NCH];

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_rn[c] = 0; m_prev[c] = 0; m_pend[c] = 0;
            m_h[c] = 1; m_p[c] = 0; m_sh_h[c] = 0; m_sh_p[c] = 0;
            m_wave[c].delete();
            m_hist[c].delete();
            for (int k = 0; k < INV_DLY; k++) m_hist[c].push_back(1'b1);
            e_clk[c] = 0; e_inv[c] = 1; e_pos[c] = 0; e_neg[c] = 0; e_busy[c] = 0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            bit o, ld, e;
            int hin, pin;
            o   = 0;
            ld  = bus.load[c];
            e   = bus.en[c];
            hin = int'(bus.half_per[c*CW +: CW]);
            pin = int'(bus.phase[c*CW +: CW]);
            if (!m_rn[c]) begin
                if (m_pend[c]) begin
                    m_h[c] = m_sh_h[c]; m_p[c] = m_sh_p[c]; m_pend[c] = 0;
                end
                if (ld) begin m_sh_h[c] = hin; m_sh_p[c] = pin; m_pend[c] = 1; end
                if (e) begin
                    m_rn[c] = 1;
                    m_wave[c].delete();
                    repeat (m_p[c] + 1) m_wave[c].push_back(1'b0);
                    o = m_wave[c].pop_front();
                end
            end else if (!m_prev[c] && !e) begin
                m_rn[c] = 0;
                m_wave[c].delete();
                if (ld) begin m_sh_h[c] = hin; m_sh_p[c] = pin; m_pend[c] = 1; end
            end else if (m_wave[c].size() != 0) begin
                o = m_wave[c].pop_front();
                if (ld) begin m_sh_h[c] = hin; m_sh_p[c] = pin; m_pend[c] = 1; end
            end else if (m_prev[c]) begin
                if (ld) begin
                    m_h[c] = hin; m_p[c] = pin; m_sh_h[c] = hin; m_sh_p[c] = pin; m_pend[c] = 0;
                end else if (m_pend[c]) begin
                    m_h[c] = m_sh_h[c]; m_p[c] = m_sh_p[c]; m_pend[c] = 0;
                end
                if (!e) m_rn[c] = 0;
                else begin
                    repeat (eff(m_h[c])) m_wave[c].push_back(1'b0);
                    o = m_wave[c].pop_front();
                end
            end else begin
                repeat (eff(m_h[c])) m_wave[c].push_back(1'b1);
                o = m_wave[c].pop_front();
                if (ld) begin m_sh_h[c] = hin; m_sh_p[c] = pin; m_pend[c] = 1; end
            end
            e_pos[c]  = o && !m_prev[c];
            e_neg[c]  = !o && m_prev[c];
            e_clk[c]  = o;
            e_busy[c] = m_pend[c];
            if (INV_DLY == 0) e_inv[c] = ~o;
            else begin
                e_inv[c] = m_hist[c].pop_front();
                m_hist[c].push_back(~o);
            end
            m_prev[c] = o;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("clk_o[%0d]", c),     bus.clk_o[c],     e_clk[c]);
            chk($sformatf("clk_inv_o[%0d]", c), bus.clk_inv_o[c], e_inv[c]);
            chk($sformatf("pos_o[%0d]", c),     bus.pos_o[c],     e_pos[c]);
            chk($sformatf("neg_o[%0d]", c),     bus.neg_o[c],     e_neg[c]);
            chk($sformatf("busy_o[%0d]", c),    bus.busy_o[c],    e_busy[c]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Pulse load on one channel with the given config for a single edge.
    task automatic cfg(input int c, input int h, input int p);
        bus.half_per[c*CW +: CW] = CW'(h);
        bus.phase[c*CW +: CW]    = CW'(p);
        bus.load[c] = 1'b1;
        cyc();
        bus.load[c] = 1'b0;
    endtask

    // Advance until the model shows a rising edge on channel c.
    task automatic wait_pos(input int c);
        int n;
        n = 0;
        cyc();
        while (!e_pos[c] && n < 1200) begin cyc(); n++; end
        if (!e_pos[c]) chk("wait_pos_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_neg(input int c);
        int n;
        n = 0;
        cyc();
        while (!e_neg[c] && n < 1200) begin cyc(); n++; end
        if (!e_neg[c]) chk("wait_neg_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = '0; bus.load = '0; bus.half_per = '0; bus.phase = '0;
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Basic H=2, P=0 wave.
        cfg(0, 2, 0);
        repeat (2) cyc();
        bus.en[0] = 1'b1;
        repeat (14) cyc();

        // Two channels, same H, phase offset 3.
        bus.en = '0;
        repeat (3) cyc();
        bus.half_per[0*CW +: CW] = 8'd4; bus.phase[0*CW +: CW] = 8'd0;
        bus.half_per[1*CW +: CW] = 8'd4; bus.phase[1*CW +: CW] = 8'd3;
        bus.load[1:0] = 2'b11;
        cyc();
        bus.load = '0;
        repeat (2) cyc();
        bus.en[1:0] = 2'b11;
        repeat (40) cyc();

        // Reconfigure H=2 -> 5 during a high half.
        bus.en = '0;
        repeat (3) cyc();
        cfg(0, 2, 0);
        repeat (2) cyc();
        bus.en[0] = 1'b1;
        repeat (6) cyc();
        wait_pos(0);
        cfg(0, 5, 0);
        repeat (30) cyc();

        // en drop while high, then while low.
        wait_pos(0);
        bus.en[0] = 1'b0;
        repeat (12) cyc();
        bus.en[0] = 1'b1;
        wait_neg(0);
        cyc();
        bus.en[0] = 1'b0;
        repeat (8) cyc();

        // Load coinciding with en drop at the falling edge.
        cfg(0, 3, 0);
        repeat (2) cyc();
        bus.en[0] = 1'b1;
        wait_pos(0);
        repeat (1) cyc();
        bus.en[0] = 1'b0;
        cfg(0, 2, 1);
        repeat (6) cyc();

        // H=0 on ch2, H=255 on ch3.
        cfg(2, 0, 0);
        cfg(3, 255, 0);
        cyc();
        bus.en[3:2] = 2'b11;
        repeat (1100) cyc();

        // Reset during high with a load pending; restart uses H=1.
        bus.en = '0;
        repeat (3) cyc();
        cfg(0, 3, 0);
        repeat (2) cyc();
        bus.en[0] = 1'b1;
        wait_pos(0);
        cfg(0, 6, 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (12) cyc();

        // Random traffic.
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(39) == 0) bus.en[c] = ~bus.en[c];
                bus.load[c] = ($urandom_range(24) == 0);
                if ($urandom_range(19) == 0) bus.half_per[c*CW +: CW] = CW'($urandom_range(30));
                else                         bus.half_per[c*CW +: CW] = CW'($urandom_range(6));
                bus.phase[c*CW +: CW] = CW'($urandom_range(5));
            end
            rst = ($urandom_range(799) == 0);
            cyc();
        end
        rst = 1'b0;
        bus.load = '0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
